// File: rtl/fifo_pkg.sv
// Shared types and helpers for the configurable flop FIFO.
//   fifo_mode_e : read-port behaviour (registered or first-word-fall-through)
//   clog2_cnt   : width of an occupancy counter able to hold 0..depth
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and error-flag control for the flop FIFO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, pop         raw requests from producer / consumer
//   err_clr           clears sticky ovf / udf (a new error in the same cycle wins)
//   wr_ptr, rd_ptr    storage addresses, wrap naturally
//   push_ok, pop_ok   qualified requests actually performed this cycle
//   count             occupancy 0..DEPTH
//   full, pndng       derived from count only
//   ovf, udf          sticky dropped-push / empty-pop flags
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = clog2_cnt(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          err_clr,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic          push_ok,
  output logic          pop_ok,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          pndng,
  output logic          ovf,
  output logic          udf
);

  assign full  = (count == CW'(DEPTH));
  assign pndng = (count != '0);

  // A pop at full frees the slot the push lands in, so it is accepted.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & pndng;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (push & ~push_ok) ovf <= 1'b1;
      else if (err_clr)    ovf <= 1'b0;

      if (pop & ~pop_ok)   udf <= 1'b1;
      else if (err_clr)    udf <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_flops_cfg.sv
// Parametrised flop-based synchronous FIFO with selectable read mode,
// occupancy count, almost-full/empty flags and sticky error flags.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   Din, push           write data / write request
//   pop                 read request
//   err_clr             clears sticky ovf / udf
//   Dout                read data (registered in FIFO_STD, head word in FIFO_FWFT)
//   full, pndng         count == DEPTH, count != 0
//   almost_full/empty   count >= AFULL_TH, count <= AEMPTY_TH
//   count               occupancy 0..DEPTH
//   ovf, udf            sticky dropped-push / empty-pop
module fifo_flops_cfg
  import fifo_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter int         BITS      = 16,
  parameter fifo_mode_e MODE      = FIFO_STD,
  parameter int         AFULL_TH  = DEPTH - 2,
  parameter int         AEMPTY_TH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [BITS-1:0]                Din,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           err_clr,
  output logic [BITS-1:0]                Dout,
  output logic                           full,
  output logic                           pndng,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic [clog2_cnt(DEPTH)-1:0]    count,
  output logic                           ovf,
  output logic                           udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = clog2_cnt(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_flops_cfg: DEPTH must be a power of two >= 2");
  end
  if (!((AEMPTY_TH < AFULL_TH) && (AFULL_TH <= DEPTH))) begin : g_bad_thresh
    $error("fifo_flops_cfg: thresholds must satisfy AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;
  logic [BITS-1:0] mem [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_ptr_ctrl (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .err_clr (err_clr),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .push_ok (push_ok),
    .pop_ok  (pop_ok),
    .count   (count),
    .full    (full),
    .pndng   (pndng),
    .ovf     (ovf),
    .udf     (udf)
  );

  assign almost_full  = (count >= CW'(AFULL_TH));
  assign almost_empty = (count <= CW'(AEMPTY_TH));

  // Storage is deliberately not reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= Din;
  end

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign Dout = pndng ? mem[rd_ptr] : '0;
  end else begin : g_std
    logic [BITS-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (rst)         dout_q <= '0;
      else if (pop_ok) dout_q <= mem[rd_ptr];
    end
    assign Dout = dout_q;
  end

endmodule

// File: tb/tb_fifo_flops_cfg.sv
module tb_fifo_flops_cfg;
  import fifo_pkg::*;

  logic        clk;
  logic        rst;

  logic [15:0] s_din, s_dout;
  logic        s_push, s_pop, s_clr;
  logic        s_full, s_pndng, s_af, s_ae, s_ovf, s_udf;
  logic [4:0]  s_count;

  logic [15:0] f_din, f_dout;
  logic        f_push, f_pop, f_clr;
  logic        f_full, f_pndng, f_af, f_ae, f_ovf, f_udf;
  logic [4:0]  f_count;

  int checks   = 0;
  int failures = 0;

  fifo_flops_cfg #(.DEPTH(16), .BITS(16), .MODE(FIFO_STD)) u_std (
    .clk (clk), .rst (rst), .Din (s_din), .push (s_push), .pop (s_pop),
    .err_clr (s_clr), .Dout (s_dout), .full (s_full), .pndng (s_pndng),
    .almost_full (s_af), .almost_empty (s_ae), .count (s_count),
    .ovf (s_ovf), .udf (s_udf)
  );

  fifo_flops_cfg #(.DEPTH(16), .BITS(16), .MODE(FIFO_FWFT)) u_fwft (
    .clk (clk), .rst (rst), .Din (f_din), .push (f_push), .pop (f_pop),
    .err_clr (f_clr), .Dout (f_dout), .full (f_full), .pndng (f_pndng),
    .almost_full (f_af), .almost_empty (f_ae), .count (f_count),
    .ovf (f_ovf), .udf (f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    s_din = '0; s_push = 0; s_pop = 0; s_clr = 0;
    f_din = '0; f_push = 0; f_pop = 0; f_clr = 0;
    #2;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_count", s_count, 0);
    check("rst_full",  s_full, 0);
    check("rst_pndng", s_pndng, 0);
    check("rst_af",    s_af, 0);
    check("rst_ae",    s_ae, 1);
    check("rst_dout",  s_dout, 0);
    check("rst_ovf",   s_ovf, 0);
    check("rst_udf",   s_udf, 0);
    check("rst_fdout", f_dout, 0);

    // Fill on alternate cycles, then drain
    for (int k = 0; k < 16; k++) begin
      s_push = 1; s_din = 16'(k);
      step();
      s_push = 0;
      check("fill_count", s_count, k + 1);
      check("fill_af",    s_af, (k + 1 >= 14));
      check("fill_full",  s_full, (k + 1 == 16));
      step();
    end
    for (int k = 0; k < 16; k++) begin
      s_pop = 1;
      step();
      s_pop = 0;
      check("drain_dout",  s_dout, k);
      check("drain_count", s_count, 15 - k);
      check("drain_ae",    s_ae, (15 - k <= 2));
      step();
    end
    check("drain_pndng", s_pndng, 0);
    check("drain_udf",   s_udf, 0);

    // Overflow: 40 pushes, no pops
    for (int k = 0; k < 40; k++) begin
      s_push = 1; s_din = 16'(k);
      step();
      check("ovf_flag",  s_ovf, (k >= 16));
      check("ovf_count", s_count, (k < 16) ? k + 1 : 16);
    end
    s_push = 0;
    for (int k = 0; k < 16; k++) begin
      s_pop = 1;
      step();
      check("ovf_drain", s_dout, k);
    end
    s_pop = 0;
    check("ovf_empty",  s_count, 0);
    check("ovf_sticky", s_ovf, 1);
    s_clr = 1;
    step();
    s_clr = 0;
    check("ovf_clr", s_ovf, 0);

    // Underflow from a fresh reset
    do_reset();
    for (int k = 0; k < 20; k++) begin
      s_pop = 1;
      step();
      check("udf_flag",  s_udf, 1);
      check("udf_count", s_count, 0);
      check("udf_dout",  s_dout, 0);
    end
    s_push = 1; s_din = 16'hA5A5;
    step();
    s_push = 0; s_pop = 0;
    check("udf_pp_count", s_count, 1);
    check("udf_pp_udf",   s_udf, 1);
    check("udf_pp_dout",  s_dout, 0);
    s_pop = 1;
    step();
    s_pop = 0;
    check("udf_pop_dout", s_dout, 16'hA5A5);
    s_clr = 1;
    step();
    s_clr = 0;
    check("udf_clr", s_udf, 0);

    // Simultaneous push/pop with 5 words preloaded
    do_reset();
    for (int k = 0; k < 5; k++) begin
      s_push = 1; s_din = 16'(k);
      step();
    end
    for (int i = 0; i < 17; i++) begin
      s_push = 1; s_pop = 1; s_din = 16'(100 + i);
      step();
      check("pp_count", s_count, 5);
      check("pp_dout",  s_dout, (i < 5) ? i : 100 + i - 5);
    end
    s_pop = 0;
    for (int k = 0; k < 11; k++) begin
      s_push = 1; s_din = 16'(200 + k);
      step();
    end
    check("pp_full", s_full, 1);
    s_push = 1; s_pop = 1; s_din = 16'h0BAD;
    step();
    s_push = 0; s_pop = 0;
    check("pp_full_count", s_count, 16);
    check("pp_full_ovf",   s_ovf, 0);
    check("pp_full_dout",  s_dout, 112);

    // FWFT: head visible without a pop, then alternate push/pop
    do_reset();
    f_push = 1; f_din = 16'd7;
    step();
    f_push = 0;
    check("fwft_show",  f_dout, 7);
    check("fwft_count", f_count, 1);
    step();
    check("fwft_hold", f_dout, 7);
    f_pop = 1;
    step();
    f_pop = 0;
    check("fwft_empty_dout", f_dout, 0);
    for (int k = 0; k <= 16; k++) begin
      f_push = 1; f_din = 16'(k + 16'h300);
      step();
      f_push = 0;
      check("fwft_alt_dout",  f_dout, k + 16'h300);
      check("fwft_alt_cnt1",  f_count, 1);
      f_pop = 1;
      step();
      f_pop = 0;
      check("fwft_alt_cnt0",  f_count, 0);
      check("fwft_alt_udf",   f_udf, 0);
    end

    // Reset mid-operation at count=9 with a pending error flag
    do_reset();
    s_pop = 1;
    step();
    s_pop = 0;
    for (int k = 0; k < 9; k++) begin
      s_push = 1; s_din = 16'(k + 1);
      step();
    end
    s_push = 0;
    check("mid_count9", s_count, 9);
    check("mid_udf1",   s_udf, 1);
    rst = 1; s_push = 1; s_din = 16'hFFFF;
    step();
    rst = 0; s_push = 0;
    check("mid_count", s_count, 0);
    check("mid_pndng", s_pndng, 0);
    check("mid_dout",  s_dout, 0);
    check("mid_ovf",   s_ovf, 0);
    check("mid_udf",   s_udf, 0);
    s_push = 1; s_din = 16'h1234;
    step();
    s_push = 0; s_pop = 1;
    step();
    s_pop = 0;
    check("mid_first", s_dout, 16'h1234);
    check("mid_after", s_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
